// File: rtl/ac97_cmd_scheduler.sv
// AC97 command-slot owner: boot delay, fixed codec init, then round-robin register writes/reads.
// Latency: write acked 1 frame after grant, read acked 2..RD_TIMEOUT+1 frames after grant.
// Backpressure: one command per frame; requesters hold req until their ack pulse.
module ac97_cmd_scheduler #(
    parameter int          NREQ        = 3,
    parameter logic [15:0] SAMPLE_RATE = 16'h1F40,
    parameter int          BOOT_FRAMES = 16,
    parameter int          RD_TIMEOUT  = 8
) (
    input  logic               clock_27mhz,
    input  logic               reset_b,
    input  logic               frame_tick,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_rw,
    input  logic [7*NREQ-1:0]  req_addr,
    input  logic [16*NREQ-1:0] req_data,
    output logic [NREQ-1:0]    ack,
    output logic               err,
    output logic [15:0]        rd_data,
    input  logic               status_valid,
    input  logic [6:0]         status_address,
    input  logic [15:0]        status_data,
    output logic [7:0]         command_address,
    output logic [15:0]        command_data,
    output logic               command_valid,
    output logic               init_done
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {BOOT, INIT, IDLE, ISSUE, WAIT_RD} state_t;

    state_t          state_q, state_d;
    logic [15:0]     boot_cnt_q, boot_cnt_d;
    logic [2:0]      init_idx_q, init_idx_d;
    logic [7:0]      to_cnt_q, to_cnt_d;
    logic [PW-1:0]   rr_q, rr_d, gnt_q, gnt_d;
    logic [6:0]      addr_q, addr_d;
    logic            rw_q, rw_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d;
    logic [15:0]     rd_data_q, rd_data_d;
    logic [7:0]      cmd_addr_q, cmd_addr_d;
    logic [15:0]     cmd_data_q, cmd_data_d;
    logic            cmd_vld_q, cmd_vld_d;
    logic            init_done_q, init_done_d;

    logic [PW-1:0]   nxt_ptr, arb_ptr, pick;
    logic            found, try_grant;
    logic [22:0]     init_ent;

    function automatic logic [22:0] init_entry(input logic [2:0] k);
        case (k)
            3'd0:    init_entry = {7'h2A, 16'h0001};
            3'd1:    init_entry = {7'h2C, SAMPLE_RATE};
            3'd2:    init_entry = {7'h32, SAMPLE_RATE};
            3'd3:    init_entry = {7'h18, 16'h0808};
            default: init_entry = {7'h1A, 16'h0000};
        endcase
    endfunction

    assign init_ent = init_entry(init_idx_q);
    assign nxt_ptr  = (int'(gnt_q) == NREQ - 1) ? '0 : gnt_q + 1'b1;
    // A write completing on this tick hands the slot on from the pointer it just advanced.
    assign arb_ptr  = (state_q == ISSUE) ? nxt_ptr : rr_q;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[(int'(arb_ptr) + i) % NREQ]) begin
                found = 1'b1;
                pick  = PW'((int'(arb_ptr) + i) % NREQ);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        init_idx_d  = init_idx_q;
        to_cnt_d    = to_cnt_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        ack_d       = '0;
        err_d       = err_q;
        rd_data_d   = rd_data_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        cmd_vld_d   = cmd_vld_q;
        init_done_d = init_done_q;
        try_grant   = 1'b0;

        case (state_q)
            BOOT: begin
                if (frame_tick) begin
                    if (boot_cnt_q == 16'(BOOT_FRAMES - 1)) begin
                        cmd_addr_d = {1'b0, init_ent[22:16]};
                        cmd_data_d = init_ent[15:0];
                        cmd_vld_d  = 1'b1;
                        init_idx_d = init_idx_q + 3'd1;
                        state_d    = INIT;
                    end else begin
                        boot_cnt_d = boot_cnt_q + 16'd1;
                    end
                end
            end
            INIT: begin
                if (frame_tick) begin
                    if (init_idx_q < 3'd5) begin
                        cmd_addr_d = {1'b0, init_ent[22:16]};
                        cmd_data_d = init_ent[15:0];
                        cmd_vld_d  = 1'b1;
                        init_idx_d = init_idx_q + 3'd1;
                    end else begin
                        cmd_vld_d   = 1'b0;
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            IDLE: begin
                if (frame_tick) begin
                    cmd_vld_d = 1'b0;
                    try_grant = 1'b1;
                end
            end
            ISSUE: begin
                if (frame_tick) begin
                    cmd_vld_d = 1'b0;
                    if (rw_q) begin
                        to_cnt_d = '0;
                        state_d  = WAIT_RD;
                    end else begin
                        ack_d[gnt_q] = 1'b1;
                        err_d        = 1'b0;
                        rr_d         = nxt_ptr;
                        state_d      = IDLE;
                        try_grant    = 1'b1;
                    end
                end
            end
            WAIT_RD: begin
                // A matching status beats a timeout tick arriving in the same cycle.
                if (status_valid && status_address == addr_q) begin
                    ack_d[gnt_q] = 1'b1;
                    err_d        = 1'b0;
                    rd_data_d    = status_data;
                    rr_d         = nxt_ptr;
                    state_d      = IDLE;
                end else if (frame_tick) begin
                    if (to_cnt_q == 8'(RD_TIMEOUT - 1)) begin
                        ack_d[gnt_q] = 1'b1;
                        err_d        = 1'b1;
                        rd_data_d    = 16'h0000;
                        rr_d         = nxt_ptr;
                        state_d      = IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = BOOT;
        endcase

        if (try_grant && found) begin
            gnt_d      = pick;
            rw_d       = req_rw[pick];
            addr_d     = req_addr[7*int'(pick) +: 7];
            cmd_addr_d = {req_rw[pick], req_addr[7*int'(pick) +: 7]};
            cmd_data_d = req_rw[pick] ? 16'h0000 : req_data[16*int'(pick) +: 16];
            cmd_vld_d  = 1'b1;
            state_d    = ISSUE;
        end
    end

    always_ff @(posedge clock_27mhz or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= BOOT;
            boot_cnt_q  <= '0;
            init_idx_q  <= '0;
            to_cnt_q    <= '0;
            rr_q        <= '0;
            gnt_q       <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cmd_vld_q   <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            init_idx_q  <= init_idx_d;
            to_cnt_q    <= to_cnt_d;
            rr_q        <= rr_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmd_vld_q   <= cmd_vld_d;
            init_done_q <= init_done_d;
        end
    end

    assign ack             = ack_q;
    assign err             = err_q;
    assign rd_data         = rd_data_q;
    assign command_address = cmd_addr_q;
    assign command_data    = cmd_data_q;
    assign command_valid   = cmd_vld_q;
    assign init_done       = init_done_q;

endmodule

// File: tb/tb_ac97_cmd_scheduler.sv
// Randomized bench for ac97_cmd_scheduler against a frame-level transaction model.
module tb_ac97_cmd_scheduler;
    localparam int          NREQ        = 3;
    localparam int          BOOT_FRAMES = 16;
    localparam int          RD_TIMEOUT  = 8;
    localparam logic [15:0] SR          = 16'h1F40;

    logic               clk = 1'b0;
    logic               reset_b;
    logic               frame_tick;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_rw;
    logic [7*NREQ-1:0]  req_addr;
    logic [16*NREQ-1:0] req_data;
    logic [NREQ-1:0]    ack;
    logic               err;
    logic [15:0]        rd_data;
    logic               status_valid;
    logic [6:0]         status_address;
    logic [15:0]        status_data;
    logic [7:0]         command_address;
    logic [15:0]        command_data;
    logic               command_valid;
    logic               init_done;

    always #5 clk = ~clk;

    ac97_cmd_scheduler #(
        .NREQ(NREQ), .SAMPLE_RATE(SR), .BOOT_FRAMES(BOOT_FRAMES), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clock_27mhz(clk), .reset_b(reset_b), .frame_tick(frame_tick),
        .req(req), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
        .ack(ack), .err(err), .rd_data(rd_data),
        .status_valid(status_valid), .status_address(status_address), .status_data(status_data),
        .command_address(command_address), .command_data(command_data),
        .command_valid(command_valid), .init_done(init_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    bit              pending [NREQ];
    bit              hold_all = 1'b0;
    bit              rand_en  = 1'b0;

    int              m_n, m_rr, m_g, m_age, resp_age, done_id;
    int              next_resp_age = 0;
    bit              m_busy, m_rw, resp_on_tick, done_rw;
    logic [6:0]      m_addr;
    logic [15:0]     resp_data, exp_rd, next_resp_data;
    logic            exp_err;
    logic [NREQ-1:0] exp_ack;
    logic [22:0]     init_tab [5];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input bit rw, input logic [6:0] a, input logic [15:0] d);
        pending[i]          = 1'b1;
        req[i]              = 1'b1;
        req_rw[i]           = rw;
        req_addr[7*i +: 7]  = a;
        req_data[16*i +: 16] = d;
    endtask

    task automatic drop_req(input int i);
        pending[i] = 1'b0;
        req[i]     = 1'b0;
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < NREQ; i++) if (pending[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Round robin: first requesting index at or after the pointer, wrapping.
    function automatic int pick_model(input int ptr);
        for (int i = 0; i < NREQ; i++)
            if (req[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        return -1;
    endfunction

    task automatic model_complete(input logic e, input logic [15:0] d);
        exp_ack[m_g] = 1'b1;
        exp_err      = e;
        if (m_rw) exp_rd = d;
        done_rw = m_rw;
        done_id = m_g;
        m_rr    = (m_g + 1) % NREQ;
        m_busy  = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_vld"},   command_valid,   0);
        check_val({tag, "_addr"},  command_address, 0);
        check_val({tag, "_data"},  command_data,    0);
        check_val({tag, "_ack"},   ack,             0);
        check_val({tag, "_err"},   err,             0);
        check_val({tag, "_rd"},    rd_data,         0);
        check_val({tag, "_idone"}, init_done,       0);
    endtask

    task automatic do_reset();
        reset_b      = 1'b0;
        frame_tick   = 1'b0;
        status_valid = 1'b0;
        req          = '0;
        for (int i = 0; i < NREQ; i++) pending[i] = 1'b0;
        m_n = 0; m_rr = 0; m_busy = 1'b0; exp_rd = '0; exp_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");
        reset_b = 1'b1;
    endtask

    task automatic frame_step();
        int ngap, g_new, k;
        bit st_tick, can;
        ngap = $urandom_range(1, 3);
        for (int c = 0; c < ngap; c++) begin
            exp_ack = '0;
            done_id = -1;
            if (c == 0 && m_busy && m_rw && m_age >= 1) begin
                if (m_age == resp_age && !resp_on_tick) begin
                    status_valid = 1'b1; status_address = m_addr; status_data = resp_data;
                    model_complete(1'b0, resp_data);
                end else if ($urandom_range(0, 1) == 1) begin
                    status_valid   = 1'b1;
                    status_address = m_addr ^ 7'($urandom_range(1, 127));
                    status_data    = 16'($urandom);
                end
            end
            @(posedge clk);
            #1;
            status_valid = 1'b0;
            check_val("gap_ack", ack, exp_ack);
            if (done_id >= 0) begin
                check_val("rd_err", err, 0);
                check_val("rd_data", rd_data, exp_rd);
                if (!hold_all) drop_req(done_id);
            end
        end

        if (rand_en)
            for (int i = 0; i < NREQ; i++)
                if (!pending[i] && $urandom_range(0, 2) == 0)
                    set_req(i, $urandom_range(0, 2) == 0, 7'($urandom), 16'($urandom));
        if (m_busy && !hold_all && req[m_g] && $urandom_range(0, 3) == 0) req[m_g] = 1'b0;

        st_tick = m_busy && m_rw && m_age == RD_TIMEOUT && resp_on_tick && resp_age == RD_TIMEOUT;
        frame_tick = 1'b1;
        if (st_tick) begin
            status_valid = 1'b1; status_address = m_addr; status_data = resp_data;
        end
        @(posedge clk);
        #1;
        frame_tick   = 1'b0;
        status_valid = 1'b0;
        m_n++;
        exp_ack = '0;
        done_id = -1;
        g_new   = -1;
        if (m_n < BOOT_FRAMES) begin
            check_val("boot_vld", command_valid, 0);
            check_val("boot_idone", init_done, 0);
        end else if (m_n < BOOT_FRAMES + 5) begin
            k = m_n - BOOT_FRAMES;
            check_val("init_vld", command_valid, 1);
            check_val("init_addr", command_address, {1'b0, init_tab[k][22:16]});
            check_val("init_data", command_data, init_tab[k][15:0]);
            check_val("init_idone", init_done, 0);
        end else if (m_n == BOOT_FRAMES + 5) begin
            check_val("initend_vld", command_valid, 0);
            check_val("initend_idone", init_done, 1);
        end else begin
            can = !m_busy;
            if (m_busy) begin
                m_age++;
                if (st_tick) model_complete(1'b0, resp_data);
                else if (!m_rw && m_age == 1) begin
                    model_complete(1'b0, exp_rd);
                    can = 1'b1;
                end else if (m_rw && m_age == RD_TIMEOUT + 1) model_complete(1'b1, 16'h0000);
            end
            if (can) g_new = pick_model(m_rr);
            check_val("cmd_vld", command_valid, g_new >= 0);
            if (g_new >= 0) begin
                m_busy = 1'b1;
                m_g    = g_new;
                m_rw   = req_rw[g_new];
                m_addr = req_addr[7*g_new +: 7];
                m_age  = 0;
                check_val("cmd_addr", command_address, {m_rw, m_addr});
                check_val("cmd_data", command_data, m_rw ? 16'h0000 : req_data[16*g_new +: 16]);
                if (m_rw) begin
                    resp_data    = 16'($urandom);
                    resp_on_tick = 1'b0;
                    if (next_resp_age != 0) begin
                        resp_age      = next_resp_age;
                        resp_data     = next_resp_data;
                        next_resp_age = 0;
                    end else if ($urandom_range(0, 3) == 0) begin
                        resp_age     = RD_TIMEOUT;
                        resp_on_tick = 1'b1;
                    end else begin
                        resp_age = $urandom_range(1, RD_TIMEOUT + 2);
                    end
                end
            end
            check_val("idone", init_done, 1);
        end
        check_val("tick_ack", ack, exp_ack);
        if (done_id >= 0) begin
            check_val("ack_err", err, exp_err);
            if (done_rw) check_val("ack_rd", rd_data, exp_rd);
            // A requester still holding req at its ack tick gets re-granted; it lets go afterwards.
            if (!hold_all) begin
                if (done_id != g_new) drop_req(done_id);
                else req[done_id] = 1'b0;
            end
        end
    endtask

    task automatic drain(input string tag);
        int b = 0;
        while ((m_busy || any_pending()) && b < 40) begin
            frame_step();
            b++;
        end
        check_val(tag, m_busy || any_pending(), 0);
    endtask

    initial begin
        int budget;
        init_tab = '{{7'h2A, 16'h0001}, {7'h2C, SR}, {7'h32, SR}, {7'h18, 16'h0808}, {7'h1A, 16'h0000}};
        req_rw = '0; req_addr = '0; req_data = '0;
        status_address = '0; status_data = '0;
        do_reset();

        // Three held writes posted during boot: granted in turn once init completes.
        hold_all = 1'b1;
        set_req(0, 1'b0, 7'h04, 16'h1111);
        set_req(1, 1'b0, 7'h0E, 16'h2222);
        set_req(2, 1'b0, 7'h1C, 16'h3333);
        repeat (BOOT_FRAMES + 5 + 4) frame_step();
        hold_all = 1'b0;
        drain("drain_wr");

        next_resp_age = 1; next_resp_data = 16'h8080;
        set_req(1, 1'b1, 7'h02, 16'hFFFF);
        drain("drain_rd");

        next_resp_age = 99;
        set_req(2, 1'b1, 7'h10, 16'h0000);
        drain("drain_to");

        rand_en = 1'b1;
        repeat (300) frame_step();

        budget = 0;
        while (!(m_busy && m_rw && m_age >= 1) && budget < 500) begin
            frame_step();
            budget++;
        end
        check_val("reach_wait_rd", m_busy && m_rw && m_age >= 1, 1);
        #2 reset_b = 1'b0;
        #1 check_zero("arst");
        do_reset();
        repeat (30) frame_step();
        rand_en = 1'b0;
        drain("drain_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
